// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit holding stage in front of the UART transmitter.
// Queues THR writes in a DEPTH-entry FIFO (fifo_en=1) or a single holding
// slot (fifo_en=0), hands bytes to the transmitter one at a time over the
// tx_data/tx_start/tx_busy handshake, and produces the THRE/TEMT flags.
// Optional build macro UART_TX_FIFO_OVERRUN_EN adds a sticky overrun flag
// (output overrun, input overrun_clr) for writes dropped on a full queue.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          fifo_en,
  input  logic          fifo_clr,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  output logic          thre,
  output logic          temt,
`ifdef UART_TX_FIFO_OVERRUN_EN
  input  logic          overrun_clr,
  output logic          overrun,
`endif
  output logic [AW:0]   level
);

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_START = 2'd1;
  localparam logic [1:0] F_BUSY  = 2'd2;

  localparam logic [AW:0] CAP_FIFO = (AW+1)'(DEPTH);
  localparam logic [AW:0] CAP_HOLD = (AW+1)'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          thre_q;
  logic          fifo_en_q;

  logic          flush;
  logic          pop;
  logic          wr_ok;
  logic [AW:0]   cap;

  // Flush, pop and write-acceptance decisions for this cycle.
  always_comb begin
    flush = fifo_clr | (fifo_en ^ fifo_en_q);
    cap   = fifo_en ? CAP_FIFO : CAP_HOLD;
    pop   = (state_q == F_IDLE) && (level_q != '0) && !flush;
    // A pop frees a slot this cycle, so a write is accepted even at capacity.
    wr_ok = wr_en && !flush && ((level_q < cap) || pop);
  end

  // Next pointers, occupancy and hold register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_d   = hold_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        hold_d   = mem_q[rd_ptr_q];
      end
      level_d = level_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    end
  end

  // Feeder FSM: pop into hold, request start, wait out the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:  if (pop)      state_d = F_START;
      F_START: if (tx_busy)  state_d = F_BUSY;
      F_BUSY:  if (!tx_busy) state_d = F_IDLE;
      default:               state_d = F_IDLE;
    endcase
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= F_IDLE;
      hold_q    <= '0;
      thre_q    <= 1'b1;
      fifo_en_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      thre_q    <= (level_d == '0);
      fifo_en_q <= fifo_en;
    end
  end

`ifdef UART_TX_FIFO_OVERRUN_EN
  logic overrun_q;

  // Sticky overrun: set on a capacity drop (not a flush drop); set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (wr_en && !flush && !wr_ok) begin
      overrun_q <= 1'b1;
    end else if (overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign overrun = overrun_q;
`endif

  assign tx_data  = hold_q;
  assign tx_start = (state_q == F_START);
  assign thre     = thre_q;
  assign temt     = thre_q && (state_q == F_IDLE) && !tx_busy;
  assign level    = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus randomized traffic for
// uart_tx_fifo, checked every cycle against a queue-based reference model
// and a behavioural transmitter that logs each byte handed over.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          fifo_en;
  logic          fifo_clr;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          thre;
  logic          temt;
  logic [AW:0]   level;
  logic          overrun;
  logic          overrun_clr;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .fifo_en     (fifo_en),
    .fifo_clr    (fifo_clr),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .thre        (thre),
    .temt        (temt),
`ifdef UART_TX_FIFO_OVERRUN_EN
    .overrun_clr (overrun_clr),
    .overrun     (overrun),
`endif
    .level       (level)
  );

`ifndef UART_TX_FIFO_OVERRUN_EN
  assign overrun = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];      // bytes waiting in the queue, head first
  logic       m_req;       // a byte was handed over, start not yet acknowledged
  logic       m_send;      // transmitter acknowledged and is sending
  logic [7:0] m_hold;      // byte currently presented to the transmitter
  logic       m_fe_prev;   // fifo_en as seen last cycle
  logic       m_ovr;

  task automatic model_reset();
    m_q.delete();
    m_req     = 1'b0;
    m_send    = 1'b0;
    m_hold    = 8'h00;
    m_fe_prev = 1'b0;
    m_ovr     = 1'b0;
  endtask

  task automatic model_step();
    bit flush, pop, acc, full_drop;
    int cap;
    flush     = fifo_clr || (fifo_en != m_fe_prev);
    cap       = fifo_en ? DEPTH : 1;
    pop       = !m_req && !m_send && (m_q.size() != 0) && !flush;
    acc       = wr_en && !flush && ((m_q.size() < cap) || pop);
    full_drop = wr_en && !flush && !acc;
    if (m_req && tx_busy) begin
      m_req  = 1'b0;
      m_send = 1'b1;
    end else if (m_send && !tx_busy) begin
      m_send = 1'b0;
    end
    if (pop) begin
      m_hold = m_q.pop_front();
      m_req  = 1'b1;
    end
    if (flush) m_q.delete();
    if (acc) m_q.push_back(wr_data);
    m_fe_prev = fifo_en;
    if (full_drop) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst) model_step();
  end

  // ---------------- transmitter model ----------------
  logic [7:0] sent[$];
  bit  stall       = 1'b0;
  bit  rand_frames = 1'b0;
  int  frame_len   = 20;
  int  frame_cnt   = 0;
  int  dly_cnt     = 0;
  int  dly_set     = 0;
  int  dly_max     = 0;
  logic prev_start = 1'b0;

  task automatic xmit_reset();
    tx_busy    = 1'b0;
    frame_cnt  = 0;
    dly_cnt    = 0;
    dly_set    = 0;
    prev_start = 1'b0;
  endtask

  // One clock: check outputs on the falling edge, then advance the
  // transmitter and clear the one-cycle strobes.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("level",    32'(level),    32'(m_q.size()));
    chk("thre",     32'(thre),     32'(m_q.size() == 0));
    chk("tx_start", 32'(tx_start), 32'(m_req));
    chk("temt",     32'(temt),     32'((m_q.size() == 0) && !m_req && !m_send && !tx_busy));
    chk("tx_data",  32'(tx_data),  32'(m_hold));
`ifdef UART_TX_FIFO_OVERRUN_EN
    chk("overrun",  32'(overrun),  32'(m_ovr));
`endif
    if (tx_start && !prev_start) sent.push_back(tx_data);
    prev_start = tx_start;
    if (stall) begin
      tx_busy   = 1'b1;
      frame_cnt = 0;
      dly_cnt   = 0;
    end else if (frame_cnt > 0) begin
      frame_cnt--;
      tx_busy = (frame_cnt != 0);
    end else if (tx_start) begin
      if (dly_cnt < dly_set) begin
        dly_cnt++;
        tx_busy = 1'b0;
      end else begin
        tx_busy   = 1'b1;
        frame_cnt = rand_frames ? int'($urandom_range(1, 12)) : frame_len;
        dly_cnt   = 0;
        dly_set   = int'($urandom_range(0, dly_max));
      end
    end else begin
      tx_busy = 1'b0;
    end
    wr_en       = 1'b0;
    fifo_clr    = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (!((m_q.size() == 0) && temt) && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'((m_q.size() == 0) && temt), 32'd1);
  endtask

  logic [7:0] exp3[16];
  int n_sent;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; fifo_en = 1'b1;
    fifo_clr = 1'b0; overrun_clr = 1'b0;
    model_reset();
    xmit_reset();
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_thre", 32'(thre), 32'd1);
    chk("rst_temt", 32'(temt), 32'd1);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(3);

    // T1: single byte latency and flag timing
    sent.delete();
    write(8'hA5);
    chk("t1_level1", 32'(level), 32'd1);
    tick();
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    chk("t1_thre", 32'(thre), 32'd1);
    chk("t1_temt0", 32'(temt), 32'd0);
    wait_idle("t1_idle", 100);
    chk("t1_temt1", 32'(temt), 32'd1);
    chk("t1_count", 32'(sent.size()), 32'd1);
    if (sent.size() > 0) chk("t1_byte", 32'(sent[0]), 32'hA5);

    // T2: saturate with a stalled transmitter, 0x10 dropped, ordered drain
    stall = 1'b1;
    write(8'hEE);
    ticks(3);
    sent.delete();
    for (int i = 0; i < 17; i++) write(8'(i));
    chk("t2_level", 32'(level), 32'd16);
`ifdef UART_TX_FIFO_OVERRUN_EN
    chk("t2_ovr", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    chk("t2_ovr_clr", 32'(overrun), 32'd0);
`endif
    stall = 1'b0;
    wait_idle("t2_idle", 1000);
    chk("t2_count", 32'(sent.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("t2_order", 32'(sent[i]), 32'(i));

    // T3: write while full in the pop cycle
    stall = 1'b1;
    write(8'hD0);
    ticks(3);
    sent.delete();
    for (int i = 0; i < 16; i++) begin
      exp3[i] = 8'($urandom);
      write(exp3[i]);
    end
    chk("t3_full", 32'(level), 32'd16);
    stall = 1'b0;
    ticks(2);
    write(8'h55);
    chk("t3_level", 32'(level), 32'd16);
    wait_idle("t3_idle", 1000);
    chk("t3_count", 32'(sent.size()), 32'd17);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("t3_order", 32'(sent[i]), 32'(exp3[i]));
    if (sent.size() == 17) chk("t3_last", 32'(sent[16]), 32'h55);

    // T4: flush with a same-cycle write during a transfer
    sent.delete();
    for (int i = 0; i < 5; i++) write(8'h40 + 8'(i));
    begin
      int g;
      g = 0;
      while (!(tx_busy && !tx_start) && g < 50) begin
        tick();
        g++;
      end
      chk("t4_busy_seen", 32'(tx_busy && !tx_start), 32'd1);
    end
    fifo_clr = 1'b1;
    write(8'h99);
    chk("t4_level", 32'(level), 32'd0);
    wait_idle("t4_idle", 100);
    ticks(30);
    chk("t4_count", 32'(sent.size()), 32'd1);
    if (sent.size() > 0) chk("t4_byte", 32'(sent[0]), 32'h40);

    // T5: single-slot mode drops the second write; mode toggle flushes
    fifo_en = 1'b0;
    ticks(2);
    stall = 1'b1;
    write(8'h77);
    ticks(3);
    sent.delete();
    write(8'h11);
    write(8'h22);
    chk("t5_level", 32'(level), 32'd1);
`ifdef UART_TX_FIFO_OVERRUN_EN
    chk("t5_ovr", 32'(overrun), 32'd1);
`endif
    stall = 1'b0;
    wait_idle("t5_idle", 200);
    chk("t5_count", 32'(sent.size()), 32'd1);
    if (sent.size() > 0) chk("t5_byte", 32'(sent[0]), 32'h11);
    stall = 1'b1;
    write(8'h77);
    ticks(3);
    sent.delete();
    write(8'h33);
    chk("t5_queued", 32'(level), 32'd1);
    fifo_en = 1'b1;
    tick();
    chk("t5_toggle", 32'(level), 32'd0);
    stall = 1'b0;
    wait_idle("t5_idle2", 200);
    ticks(10);
    chk("t5_none", 32'(sent.size()), 32'd0);

    // T6: reset while a start request is pending
    dly_set = 5;
    dly_cnt = 0;
    write(8'hC3);
    begin
      int g;
      g = 0;
      while (!tx_start && g < 10) begin
        tick();
        g++;
      end
      chk("t6_start_seen", 32'(tx_start), 32'd1);
    end
    #2;
    rst = 1'b1;
    model_reset();
    xmit_reset();
    #1;
    chk("t6_start", 32'(tx_start), 32'd0);
    chk("t6_thre", 32'(thre), 32'd1);
    chk("t6_temt", 32'(temt), 32'd1);
    chk("t6_level", 32'(level), 32'd0);
    ticks(3);
    rst = 1'b0;
    n_sent = sent.size();
    ticks(30);
    chk("t6_no_tx", 32'(sent.size()), 32'(n_sent));

    // Randomized traffic
    rand_frames = 1'b1;
    dly_max = 2;
    for (int c = 0; c < 2500; c++) begin
      wr_en       = ($urandom_range(0, 2) != 0);
      wr_data     = 8'($urandom);
      fifo_clr    = ($urandom_range(0, 59) == 0);
      overrun_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) fifo_en = ~fifo_en;
      if ($urandom_range(0, 99) == 0) stall = ~stall;
      tick();
    end
    stall = 1'b0;
    wait_idle("rand_idle", 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit holding stage placed directly upstream of the UART transmitter.
- Buffers bytes written by the register interface (THR writes) in a DEPTH-entry FIFO, or in a single holding slot when FIFO mode is off (16450 mode).
- Feeds one byte at a time to the transmitter over the tx_data/tx_start/tx_busy handshake.
- Generates the THRE and TEMT line-status flags.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- AW, 4, pointer width; AW = log2(DEPTH).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- wr_en  input  1  one-cycle THR write strobe
- wr_data  input  8  byte to enqueue
- fifo_en  input  1  FCR[0]; 1 = DEPTH-entry FIFO, 0 = single-entry holding register
- fifo_clr  input  1  FCR[2] one-cycle pulse; flush queued bytes
- tx_busy  input  1  transmitter busy (active or pending)
- tx_data  output  8  byte presented to transmitter
- tx_start  output  1  start request to transmitter
- thre  output  1  LSR[5]; no bytes queued
- temt  output  1  LSR[6]; queue, holding register and transmitter all empty
- level  output  AW+1  number of queued bytes (0..DEPTH)

Behaviour:
- Reset (async, immediate):
  - pointers, level = 0; feeder state = F_IDLE.
  - tx_data = 8'h00, tx_start = 0, thre = 1, temt = 1.
- Capacity: cap = DEPTH when fifo_en = 1, else 1.
- Write acceptance:
  - wr_en is accepted if level < cap, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and pointers are unchanged.
  - Accepted data is stored at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap of AW bits).
- Flush: fifo_clr = 1, or any change of fifo_en (detected against a registered copy), does the following in that cycle:
  - rd_ptr = wr_ptr = 0, level = 0.
  - A wr_en in the same cycle is dropped (flush wins).
  - A pop in the same cycle is suppressed.
  - Flush does not affect the holding register or a byte already handed to the transmitter.
- Feeder FSM (registered state):
  - F_IDLE: if level ≠ 0 and no flush → pop the head into the hold register, rd_ptr++, go to F_START.
  - F_START: tx_start = 1 (decoded from state). Stay until tx_busy = 1, then go to F_BUSY.
  - F_BUSY: tx_start = 0. When tx_busy = 0, go to F_IDLE.
  - tx_data is driven from the hold register. It is stable from the F_START entry through the F_BUSY exit.
  - The hold register is written only on a pop.
- Latency: a write into an empty queue with the feeder in F_IDLE at cycle N gives:
  - level = 1 at N+1.
  - Pop at N+1 (level back to 0 at N+2).
  - tx_start high at N+2.
- Back-to-back: after tx_busy falls, the next pop occurs the cycle after F_BUSY→F_IDLE. The minimum gap between the tx_busy fall and the next tx_start is 2 cycles.
- Simultaneous write and pop:
  - level unchanged.
  - Accepted even when level = cap.
  - Pop reads the old head.
- Level update rule: level_next = level + (write accepted) − (pop).
- thre = (level == 0), registered copy of level_next.
- temt = thre && state == F_IDLE && !tx_busy (combinational from registers and tx_busy).
- Reset mid-transfer: tx_start drops immediately; the queued contents are lost.
- Non-FIFO mode: a second write while the single slot is occupied and not popping is dropped.

Optional Feature:
- Macro UART_TX_FIFO_OVERRUN_EN.
- Defined:
  - Adds output overrun (1 bit) and input overrun_clr (1 bit).
  - overrun sets sticky on any dropped write caused by a full queue. A flush-dropped write does not set it.
  - overrun clears on overrun_clr or reset; set wins on a same-cycle clear.
- Undefined:
  - Both ports are absent.
  - Full-queue writes are dropped silently.
  - No extra logic.

Test Plan:
- FIFO mode, tx_busy model with a 20-cycle frame; write 8'hA5 at cycle 10 → level = 1 at 11, tx_start high at 12 with tx_data = 8'hA5, thre = 1 from 12, temt = 0 until tx_busy falls, then temt = 1.
- FIFO mode, 17 consecutive writes 8'h00..8'h10 with transmitter stalled (tx_busy held 1) → level saturates at 16, 8'h10 dropped (overrun = 1 with macro); releasing tx_busy delivers 8'h00..8'h0F in order.
- Fill to level = 16 in F_IDLE, then write 8'h55 in the pop cycle → accepted, level stays 16, 8'h55 emitted last.
- Queue 5 bytes, assert fifo_clr together with wr_en during F_BUSY → level = 0, write dropped, in-flight byte completes, no further tx_start, temt = 1 after tx_busy falls.
- fifo_en = 0, write 8'h11 then 8'h22 while slot occupied → only 8'h11 transmitted. Toggle fifo_en with 1 byte queued → flush, level = 0.
- Assert rst during F_START → tx_start = 0 and thre = temt = 1 in the same cycle; no transmission after release.
